// File: rtl/mac_dot_scheduler.sv
// FP32 dot-product sequencer: interleaves Latency partial sums through one shared MAC, then folds them.
// Latency: issues registered one cycle after transfer; done ~len + Latency + 14*(Latency-1) cycles after start.
// Backpressure: in_valid=0 inserts MAC bubbles; in_ready drops once len pairs have been accepted.
module mac_dot_scheduler #(
  parameter int DataWidth = 32,
  parameter int Latency   = 12,
  parameter int CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CntWidth-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] result,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] w_in,
  input  logic [DataWidth-1:0] i_in,
  output logic                 mac_nop,
  output logic [DataWidth-1:0] mac_w,
  output logic [DataWidth-1:0] mac_i,
  output logic [DataWidth-1:0] mac_o,
  input  logic                 mac_nop_out,
  input  logic [DataWidth-1:0] mac_data_out
);
  localparam int SlotW = (Latency > 1) ? $clog2(Latency) : 1;
  localparam int IfW   = $clog2(Latency + 2);
  localparam logic [DataWidth-1:0] FpOne = DataWidth'(32'h3F80_0000);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(Latency - 1);

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, RED_ISSUE, RED_WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [CntWidth-1:0]  len_q, k;
  logic [SlotW-1:0]     slot, j, iss_slot;
  logic [IfW-1:0]       inflight;
  logic [DataWidth-1:0] psum [Latency];
  logic [DataWidth-1:0] acc, mac_o_q, byp_o;
  logic                 tag_vld [Latency];
  logic [SlotW-1:0]     tag_slot [Latency];
  logic                 fwd, fwd_nxt, xfer, land, stream_phase, land_stream;

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign in_ready     = (state == STREAM) && (k < len_q);
  assign xfer         = in_valid & in_ready;
  assign stream_phase = (state == STREAM) || (state == DRAIN);
  assign land         = ~mac_nop_out & tag_vld[Latency-1];
  assign land_stream  = land & stream_phase;
  assign byp_o        = (land && tag_slot[Latency-1] == slot) ? mac_data_out : psum[slot];
  // The previous issue to this slot lands in the very cycle the new issue is presented,
  // so its sum is muxed straight from the MAC output onto O_Data.
  assign fwd_nxt      = tag_vld[Latency-2] && (tag_slot[Latency-2] == slot);
  assign mac_o        = fwd ? mac_data_out : mac_o_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = (len == '0) ? DONE : STREAM;
      STREAM:    if (xfer && (k + CntWidth'(1) == len_q)) state_nxt = DRAIN;
      DRAIN:     if (inflight == '0) state_nxt = RED_ISSUE;
      RED_ISSUE: state_nxt = RED_WAIT;
      RED_WAIT:  if (land) state_nxt = (j == LastSlot) ? DONE : RED_ISSUE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      k        <= '0;
      slot     <= '0;
      j        <= '0;
      iss_slot <= '0;
      inflight <= '0;
      acc      <= '0;
      result   <= '0;
      mac_nop  <= 1'b1;
      mac_w    <= '0;
      mac_i    <= '0;
      mac_o_q  <= '0;
      fwd      <= 1'b0;
      for (int s = 0; s < Latency; s++) begin
        psum[s]     <= '0;
        tag_vld[s]  <= 1'b0;
        tag_slot[s] <= '0;
      end
    end else begin
      mac_nop  <= 1'b1;
      mac_w    <= '0;
      mac_i    <= '0;
      mac_o_q  <= '0;
      fwd      <= 1'b0;
      inflight <= inflight + IfW'(xfer) - IfW'(land_stream);
      // Tag rides alongside the presented issue so it emerges with the matching MAC result.
      tag_vld[0]  <= ~mac_nop;
      tag_slot[0] <= iss_slot;
      for (int s = 1; s < Latency; s++) begin
        tag_vld[s]  <= tag_vld[s-1];
        tag_slot[s] <= tag_slot[s-1];
      end
      if (land_stream) psum[tag_slot[Latency-1]] <= mac_data_out;

      unique case (state)
        IDLE: if (start) begin
          len_q <= len;
          k     <= '0;
          slot  <= '0;
          acc   <= '0;
          for (int s = 0; s < Latency; s++) psum[s] <= '0;
          if (len == '0) result <= '0;
        end
        STREAM: if (xfer) begin
          mac_nop  <= 1'b0;
          mac_w    <= w_in;
          mac_i    <= i_in;
          mac_o_q  <= byp_o;
          fwd      <= fwd_nxt;
          iss_slot <= slot;
          slot     <= (slot == LastSlot) ? '0 : slot + SlotW'(1);
          k        <= k + CntWidth'(1);
        end
        DRAIN: if (inflight == '0) begin
          acc <= psum[0];
          j   <= SlotW'(1);
        end
        RED_ISSUE: begin
          mac_nop <= 1'b0;
          mac_w   <= FpOne;
          mac_i   <= psum[j];
          mac_o_q <= acc;
        end
        RED_WAIT: if (land) begin
          acc <= mac_data_out;
          j   <= j + SlotW'(1);
          if (j == LastSlot) result <= mac_data_out;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Bench for mac_dot_scheduler with a behavioural 12-cycle MAC on integer-valued FP32 operands.
module tb_mac_dot_scheduler;
  localparam int L = 12;

  logic        clk, rst, start, busy, done, in_valid, in_ready;
  logic [15:0] len;
  logic [31:0] result, w_in, i_in, mac_w, mac_i, mac_o, mac_data_out;
  logic        mac_nop, mac_nop_out;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] sb[$];
  int prods[$];
  logic [31:0] wq[$], iq[$];
  int cur_len = 0, iss_n = 0, first_iss = -1, last_iss = -1, cyc_cnt = 0;
  bit mon_en = 0;

  mac_dot_scheduler #(.DataWidth(32), .Latency(L), .CntWidth(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .result(result), .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in), .i_in(i_in),
    .mac_nop(mac_nop), .mac_w(mac_w), .mac_i(mac_i), .mac_o(mac_o),
    .mac_nop_out(mac_nop_out), .mac_data_out(mac_data_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int fp2int(input logic [31:0] f);
    int e, m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({8'd0, 1'b1, f[22:0]});
    if (e < 0) m = 0;
    else if (e <= 23) m = m >> (23 - e);
    else m = m << (e - 23);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    logic [31:0] mag, sh;
    int p;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int b = 0; b < 24; b++) if (mag[b]) p = b;
    sh = mag << (23 - p);
    return {v < 0, 8'(127 + p), sh[22:0]};
  endfunction

  // Behavioural MAC: W*I+O, 12 cycles, cleared by the same reset.
  logic        pipe_nop [L];
  logic [31:0] pipe_dat [L];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < L; s++) begin pipe_nop[s] <= 1'b1; pipe_dat[s] <= 32'h0; end
    end else begin
      pipe_nop[0] <= mac_nop;
      pipe_dat[0] <= int2fp(fp2int(mac_w) * fp2int(mac_i) + fp2int(mac_o));
      for (int s = 1; s < L; s++) begin pipe_nop[s] <= pipe_nop[s-1]; pipe_dat[s] <= pipe_dat[s-1]; end
    end
  end
  assign mac_nop_out  = pipe_nop[L-1];
  assign mac_data_out = pipe_dat[L-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue monitor: the n-th stream issue must carry the sum of earlier products in its slot.
  always @(negedge clk) begin : mon
    int s, e, jj;
    cyc_cnt++;
    if (mon_en && !mac_nop) begin
      if (iss_n < cur_len) begin
        s = iss_n % L; e = 0;
        for (int m = 0; m < iss_n; m++) if (m % L == s) e += prods[m];
        check("iss_w", mac_w, wq[iss_n]);
        check("iss_i", mac_i, iq[iss_n]);
        check("iss_o_psum_byp", mac_o, int2fp(e));
        if (first_iss < 0) first_iss = cyc_cnt;
        last_iss = cyc_cnt;
      end else if (iss_n < cur_len + L - 1) begin
        jj = iss_n - cur_len + 1;
        s = 0; e = 0;
        for (int m = 0; m < prods.size(); m++) begin
          if (m % L == jj) s += prods[m];
          if (m % L < jj) e += prods[m];
        end
        check("red_w", mac_w, 32'h3F800000);
        check("red_i", mac_i, int2fp(s));
        check("red_o", mac_o, int2fp(e));
      end else check("extra_issue", iss_n, cur_len + L - 2);
      iss_n++;
    end
    if (mon_en && in_valid && in_ready) begin
      prods.push_back(fp2int(w_in) * fp2int(i_in));
      wq.push_back(w_in);
      iq.push_back(i_in);
    end
  end

  task automatic arm_monitor(input int n);
    cur_len = n; prods.delete(); wq.delete(); iq.delete();
    iss_n = 0; first_iss = -1; last_iss = -1; mon_en = 1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_in_ready"}, in_ready, 0);
    check({pfx, "_mac_nop"}, mac_nop, 1);
    check({pfx, "_result"}, result, 0);
    check({pfx, "_mac_w"}, mac_w, 0);
    check({pfx, "_mac_i"}, mac_i, 0);
    check({pfx, "_mac_o"}, mac_o, 0);
  endtask

  task automatic run_op(input int n, input logic [31:0] w, input logic [31:0] iv, input bit alt, input bit stall);
    int cnt, cyc_n, done_cyc, exp_sum;
    bit got, late_rdy;
    logic [31:0] exp_res;
    exp_sum = 0;
    for (int m = 0; m < n; m++) exp_sum += fp2int(w) * ((alt && (m % 2 == 1)) ? -fp2int(iv) : fp2int(iv));
    sb.push_back(int2fp(exp_sum));
    arm_monitor(n);
    start = 1; len = 16'(n);
    @(posedge clk); #1;
    start = 0;
    cnt = 0; got = 0; late_rdy = 0; done_cyc = 0;
    for (cyc_n = 1; cyc_n <= 1500 && !got; cyc_n++) begin
      in_valid = (cnt < n) && (!stall || $urandom_range(0, 1) == 1);
      w_in = w;
      i_in = (alt && (cnt % 2 == 1)) ? (iv ^ 32'h8000_0000) : iv;
      @(negedge clk);
      if (cyc_n == 1) check("busy_after_start", busy, 1);
      if (n == 0) check("len0_mac_nop", mac_nop, 1);
      if (cnt >= n && in_ready) late_rdy = 1;
      if (in_valid && in_ready) cnt++;
      if (done) begin got = 1; done_cyc = cyc_n; end
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("done_seen", got, 1);
    check("done_one_cycle", done, 0);
    exp_res = sb.pop_front();
    check("result", result, exp_res);
    check("in_ready_after_len", late_rdy, 0);
    check("issue_count", iss_n, (n > 0) ? n + L - 1 : 0);
    if (n == 0) check("len0_done_within_2", done_cyc <= 2, 1);
    if (!stall && n > 0) check("back_to_back", last_iss - first_iss, n - 1);
    mon_en = 0;
  endtask

  initial begin
    int cnt;
    bit seen_done, seen_iss;
    rst = 0; start = 0; len = 0; in_valid = 0; w_in = 0; i_in = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1;
    @(posedge clk); #1;

    run_op(4,  32'h3F800000, 32'h40000000, 0, 0);
    run_op(24, 32'h3F800000, 32'h3F800000, 0, 0);
    run_op(13, 32'h3F800000, 32'h3F800000, 0, 1);
    run_op(0,  32'h3F800000, 32'h3F800000, 0, 0);

    // Abort: second start while busy must be ignored, then reset mid-STREAM.
    arm_monitor(20);
    start = 1; len = 16'd20;
    @(posedge clk); #1;
    start = 0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1; w_in = 32'h3F800000; i_in = 32'h3F800000;
      start = (c == 4); len = (c == 4) ? 16'd3 : 16'd20;
      @(negedge clk);
      if (in_valid && in_ready) cnt++;
      @(posedge clk); #1;
    end
    start = 0;
    @(negedge clk);
    check("restart_ignored_rdy", in_ready, 1);
    check("restart_ignored_busy", busy, 1);
    check("restart_xfers", cnt, 10);
    @(posedge clk); #1;
    rst = 0; mon_en = 0; in_valid = 0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1 rst = 1;
    seen_done = 0; seen_iss = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) seen_done = 1;
      if (!mac_nop) seen_iss = 1;
    end
    check("no_done_after_abort", seen_done, 0);
    check("idle_after_abort", seen_iss, 0);
    @(posedge clk); #1;

    run_op(1,  32'h40400000, 32'h40000000, 0, 0);
    run_op(12, 32'h3F800000, 32'h3F800000, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
